// File: rtl/bp_pkg.sv
// Branch predictor shared definitions.
// Counter constants and PC field extraction helpers.
package bp_pkg;

  localparam int PC_INC = 4;

  // Strongest taken value of a WID-bit direction counter.
  function automatic int unsigned cnt_max(input int wid);
    return (32'd1 << wid) - 32'd1;
  endfunction

  // Lowest counter value that predicts taken.
  function automatic int unsigned weak_taken(input int wid);
    return 32'd1 << (wid - 1);
  endfunction

  // Highest counter value that predicts not-taken.
  function automatic int unsigned weak_not_taken(input int wid);
    return (32'd1 << (wid - 1)) - 32'd1;
  endfunction

  // Table index: word-aligned low PC bits.
  function automatic logic [63:0] pc_idx(
    input logic [63:0] pc,
    input int          idx_wid
  );
    return (pc >> 2) & ((64'd1 << idx_wid) - 64'd1);
  endfunction

  // Stored tag: PC bits directly above the index.
  function automatic logic [63:0] pc_tag(
    input logic [63:0] pc,
    input int          idx_wid,
    input int          tag_wid
  );
    return (pc >> (idx_wid + 2)) & ((64'd1 << tag_wid) - 64'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating counter next-value step.
// Up/down clamp at 0 and max; force_max jumps to max.
module sat_counter #(
  parameter int WID = 2
) (
  input  logic [WID-1:0] cur,
  input  logic           inc,
  input  logic           dec,
  input  logic           force_max,
  output logic [WID-1:0] nxt
);

  localparam logic [WID-1:0] MAX = '1;

  // Pick the next value; callers keep inc/dec/force_max exclusive.
  always_comb begin
    nxt = cur;
    unique case (1'b1)
      force_max: nxt = MAX;
      inc:       nxt = (cur == MAX) ? cur : cur + 1'b1;
      dec:       nxt = (cur == '0) ? cur : cur - 1'b1;
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters.
// Combinational lookup, registered update, saturating stats.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WID   = 32,
  parameter int ENTRIES  = 16,
  parameter int TAG_WID  = 8,
  parameter int CNT_WID  = 2,
  parameter int STAT_WID = 16,
  parameter int ENABLE   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WID-1:0]   lookup_pc,
  output logic                predict_taken,
  output logic [PC_WID-1:0]   predict_target,
  input  logic                upd_valid,
  input  logic [PC_WID-1:0]   upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WID-1:0]   upd_target,
  input  logic                upd_is_branch,
  input  logic                upd_mispredict,
  output logic [STAT_WID-1:0] stat_updates,
  output logic [STAT_WID-1:0] stat_mispredicts
);

  localparam int IDX_WID = $clog2(ENTRIES);

  localparam logic [CNT_WID-1:0] CNT_MAX =
    CNT_WID'(cnt_max(CNT_WID));
  localparam logic [CNT_WID-1:0] WEAK_T =
    CNT_WID'(weak_taken(CNT_WID));
  localparam logic [CNT_WID-1:0] WEAK_NT =
    CNT_WID'(weak_not_taken(CNT_WID));

  typedef struct packed {
    logic               valid;
    logic [TAG_WID-1:0] tag;
    logic [PC_WID-1:0]  target;
    logic [CNT_WID-1:0] cnt;
  } bp_entry_t;

  bp_entry_t tbl [ENTRIES];

  logic [IDX_WID-1:0] l_idx;
  logic [TAG_WID-1:0] l_tag;
  bp_entry_t          l_ent;
  logic               l_hit;

  logic [IDX_WID-1:0] u_idx;
  logic [TAG_WID-1:0] u_tag;
  bp_entry_t          u_ent;
  logic               u_hit;
  logic [CNT_WID-1:0] cnt_nxt;

  logic [STAT_WID-1:0] upd_cnt_nxt;
  logic [STAT_WID-1:0] mis_cnt_nxt;

  // Split both PCs into index and tag.
  always_comb begin
    l_idx = IDX_WID'(pc_idx(64'(lookup_pc), IDX_WID));
    l_tag = TAG_WID'(pc_tag(64'(lookup_pc), IDX_WID, TAG_WID));
    u_idx = IDX_WID'(pc_idx(64'(upd_pc), IDX_WID));
    u_tag = TAG_WID'(pc_tag(64'(upd_pc), IDX_WID, TAG_WID));
  end

  // Zero-latency prediction from pre-update table contents.
  always_comb begin
    l_ent          = tbl[l_idx];
    l_hit          = l_ent.valid && (l_ent.tag == l_tag);
    predict_taken  = (ENABLE != 0) && l_hit && l_ent.cnt[CNT_WID-1];
    predict_target = predict_taken
                   ? l_ent.target
                   : lookup_pc + PC_WID'(PC_INC);
  end

  // Resolved-entry view feeding the counter step.
  always_comb begin
    u_ent = tbl[u_idx];
    u_hit = u_ent.valid && (u_ent.tag == u_tag);
  end

  sat_counter #(.WID(CNT_WID)) u_dir (
    .cur       (u_ent.cnt),
    .inc       (upd_is_branch && upd_taken),
    .dec       (upd_is_branch && !upd_taken),
    .force_max (!upd_is_branch),
    .nxt       (cnt_nxt)
  );

  sat_counter #(.WID(STAT_WID)) u_stat_upd (
    .cur       (stat_updates),
    .inc       (upd_valid),
    .dec       (1'b0),
    .force_max (1'b0),
    .nxt       (upd_cnt_nxt)
  );

  sat_counter #(.WID(STAT_WID)) u_stat_mis (
    .cur       (stat_mispredicts),
    .inc       (upd_valid && upd_mispredict),
    .dec       (1'b0),
    .force_max (1'b0),
    .nxt       (mis_cnt_nxt)
  );

  // Train on hit, allocate on taken miss, ignore not-taken miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WEAK_NT};
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        tbl[u_idx].cnt <= cnt_nxt;
        if (upd_taken) tbl[u_idx].target <= upd_target;
      end else if (upd_taken) begin
        tbl[u_idx] <= '{
          valid:  1'b1,
          tag:    u_tag,
          target: upd_target,
          cnt:    upd_is_branch ? WEAK_T : CNT_MAX
        };
      end
    end
  end

  // Saturating debug statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_updates     <= upd_cnt_nxt;
      stat_mispredicts <= mis_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor.
// Dynamic and static-mode instances share stimulus.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_is_branch = 1'b0;
  logic        upd_mispredict = 1'b0;

  logic        p_taken;
  logic [31:0] p_target;
  logic [3:0]  s_upd;
  logic [3:0]  s_mis;
  logic        p0_taken;
  logic [31:0] p0_target;
  logic [3:0]  s0_upd;
  logic [3:0]  s0_mis;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .PC_WID(32), .ENTRIES(16), .TAG_WID(8),
    .CNT_WID(2), .STAT_WID(4), .ENABLE(1)
  ) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .predict_taken(p_taken), .predict_target(p_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_is_branch(upd_is_branch),
    .upd_mispredict(upd_mispredict),
    .stat_updates(s_upd), .stat_mispredicts(s_mis)
  );

  branch_predictor #(
    .PC_WID(32), .ENTRIES(16), .TAG_WID(8),
    .CNT_WID(2), .STAT_WID(4), .ENABLE(0)
  ) dut_static (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .predict_taken(p0_taken), .predict_target(p0_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_is_branch(upd_is_branch),
    .upd_mispredict(upd_mispredict),
    .stat_updates(s0_upd), .stat_mispredicts(s0_mis)
  );

  task automatic do_upd(
    input logic [31:0] pc,
    input logic        tk,
    input logic [31:0] tgt,
    input logic        br,
    input logic        mis
  );
    @(negedge clk);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_is_branch  = br;
    upd_mispredict = mis;
    @(posedge clk);
    #1;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 32'h100;
    upd_taken = 1'b1;
    upd_target = 32'h80;
    upd_is_branch = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    upd_valid = 1'b0;
    look(32'h40);
    n_cmp++;
    if (p_taken !== 1'b0 || p_target !== 32'h44) begin
      n_bad++;
      $display("FAIL reset_lookup: got %b/%h want 0/00000044",
               p_taken, p_target);
    end
    n_cmp++;
    if (s_upd !== 4'd0 || s_mis !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", s_upd, s_mis);
    end
    look(32'h100);
    n_cmp++;
    if (p_taken !== 1'b0 || p_target !== 32'h104) begin
      n_bad++;
      $display("FAIL reset_drop_upd: got %b/%h want 0/00000104",
               p_taken, p_target);
    end
  endtask

  task automatic test_train_up();
    do_upd(32'h100, 1'b1, 32'h80, 1'b1, 1'b0);
    look(32'h100);
    n_cmp++;
    if (p_taken !== 1'b1 || p_target !== 32'h80) begin
      n_bad++;
      $display("FAIL alloc_taken: got %b/%h want 1/00000080",
               p_taken, p_target);
    end
    n_cmp++;
    if (p0_taken !== 1'b0 || p0_target !== 32'h104) begin
      n_bad++;
      $display("FAIL static_alloc: got %b/%h want 0/00000104",
               p0_taken, p0_target);
    end
    look(32'h40);
    n_cmp++;
    if (p_taken !== 1'b0 || p_target !== 32'h44) begin
      n_bad++;
      $display("FAIL tag_miss: got %b/%h want 0/00000044",
               p_taken, p_target);
    end
    do_upd(32'h100, 1'b1, 32'h80, 1'b1, 1'b0);
    do_upd(32'h100, 1'b1, 32'h80, 1'b1, 1'b0);
    look(32'h100);
    n_cmp++;
    if (p_taken !== 1'b1 || p_target !== 32'h80) begin
      n_bad++;
      $display("FAIL cnt_max: got %b/%h want 1/00000080",
               p_taken, p_target);
    end
  endtask

  task automatic test_train_down();
    do_upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
    look(32'h100);
    n_cmp++;
    if (p_taken !== 1'b1 || p_target !== 32'h80) begin
      n_bad++;
      $display("FAIL cnt_3_to_2: got %b/%h want 1/00000080",
               p_taken, p_target);
    end
    do_upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
    look(32'h100);
    n_cmp++;
    if (p_taken !== 1'b0 || p_target !== 32'h104) begin
      n_bad++;
      $display("FAIL cnt_2_to_1: got %b/%h want 0/00000104",
               p_taken, p_target);
    end
    do_upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
    do_upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
    do_upd(32'h100, 1'b1, 32'h80, 1'b1, 1'b0);
    look(32'h100);
    n_cmp++;
    if (p_taken !== 1'b0 || p_target !== 32'h104) begin
      n_bad++;
      $display("FAIL cnt_floor: got %b/%h want 0/00000104",
               p_taken, p_target);
    end
  endtask

  task automatic test_alias();
    // 0x1100 shares index 0 with 0x100 but differs in tag
    do_upd(32'h1100, 1'b1, 32'h200, 1'b1, 1'b0);
    look(32'h1100);
    n_cmp++;
    if (p_taken !== 1'b1 || p_target !== 32'h200) begin
      n_bad++;
      $display("FAIL alias_new: got %b/%h want 1/00000200",
               p_taken, p_target);
    end
    look(32'h100);
    n_cmp++;
    if (p_taken !== 1'b0 || p_target !== 32'h104) begin
      n_bad++;
      $display("FAIL alias_evicted: got %b/%h want 0/00000104",
               p_taken, p_target);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    upd_valid     = 1'b1;
    upd_pc        = 32'h300;
    upd_taken     = 1'b1;
    upd_target    = 32'h40;
    upd_is_branch = 1'b1;
    lookup_pc     = 32'h300;
    #1;
    n_cmp++;
    if (p_taken !== 1'b0 || p_target !== 32'h304) begin
      n_bad++;
      $display("FAIL same_cycle_old: got %b/%h want 0/00000304",
               p_taken, p_target);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
    n_cmp++;
    if (p_taken !== 1'b1 || p_target !== 32'h40) begin
      n_bad++;
      $display("FAIL same_cycle_new: got %b/%h want 1/00000040",
               p_taken, p_target);
    end
  endtask

  task automatic test_jal();
    do_upd(32'h500, 1'b1, 32'h900, 1'b0, 1'b0);
    do_upd(32'h500, 1'b0, 32'h0, 1'b1, 1'b0);
    look(32'h500);
    n_cmp++;
    if (p_taken !== 1'b1 || p_target !== 32'h900) begin
      n_bad++;
      $display("FAIL jal_max: got %b/%h want 1/00000900",
               p_taken, p_target);
    end
    n_cmp++;
    if (p0_taken !== 1'b0 || p0_target !== 32'h504) begin
      n_bad++;
      $display("FAIL static_jal: got %b/%h want 0/00000504",
               p0_taken, p0_target);
    end
  endtask

  task automatic test_stats();
    hard_reset();
    @(negedge clk);
    upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    upd_mispredict = 1'b0;
    n_cmp++;
    if (s_upd !== 4'd0 || s_mis !== 4'd0) begin
      n_bad++;
      $display("FAIL mis_no_valid: got %0d/%0d want 0/0", s_upd, s_mis);
    end
    for (int i = 0; i < 5; i++) begin
      do_upd(32'h700, 1'b0, 32'h0, 1'b1, (i >= 3));
    end
    n_cmp++;
    if (s_upd !== 4'd5 || s_mis !== 4'd2) begin
      n_bad++;
      $display("FAIL stats_mix: got %0d/%0d want 5/2", s_upd, s_mis);
    end
    n_cmp++;
    if (s0_upd !== 4'd5 || s0_mis !== 4'd2) begin
      n_bad++;
      $display("FAIL static_stats: got %0d/%0d want 5/2", s0_upd, s0_mis);
    end
    for (int i = 0; i < 20; i++) begin
      do_upd(32'h100, 1'b1, 32'h80, 1'b1, 1'b1);
    end
    n_cmp++;
    if (s_upd !== 4'd15 || s_mis !== 4'd15) begin
      n_bad++;
      $display("FAIL stats_sat: got %0d/%0d want 15/15", s_upd, s_mis);
    end
    look(32'h100);
    n_cmp++;
    if (p_taken !== 1'b1 || p_target !== 32'h80) begin
      n_bad++;
      $display("FAIL pre_rst_pred: got %b/%h want 1/00000080",
               p_taken, p_target);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (s_upd !== 4'd0 || s_mis !== 4'd0) begin
      n_bad++;
      $display("FAIL async_rst_stats: got %0d/%0d want 0/0", s_upd, s_mis);
    end
    n_cmp++;
    if (p_taken !== 1'b0 || p_target !== 32'h104) begin
      n_bad++;
      $display("FAIL async_rst_pred: got %b/%h want 0/00000104",
               p_taken, p_target);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_train_up();
    test_train_down();
    test_alias();
    test_same_cycle();
    test_jal();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
